// File: rtl/interrupt_return_stack.sv
// interrupt_return_stack: LIFO of interrupted {return address, priority} for nested handlers; optional error flags via INTERRUPT_RETURN_STACK_ERR_EN
module interrupt_return_stack #(
  parameter int AddrWidth = 32,
  parameter int PrioWidth = 3,
  parameter int Depth = 8,
  localparam int LvlW = $clog2(Depth + 1),
  localparam int IdxW = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [AddrWidth-1:0] push_addr,
  input  logic [PrioWidth-1:0] push_prio,
  input  logic                 pop,
  input  logic                 clear_err,
  output logic [AddrWidth-1:0] ret_addr,
  output logic [PrioWidth-1:0] ret_prio,
  output logic                 ret_valid,
  output logic [LvlW-1:0]      level,
  output logic                 overflow,
  output logic                 underflow
);
  logic [AddrWidth-1:0] addr_q [Depth];
  logic [PrioWidth-1:0] prio_q [Depth];
  logic [LvlW-1:0] level_q, level_d;
  logic full, empty, do_push, do_pop, push_err, pop_err;
  logic [IdxW-1:0] top_idx;
  assign full = level_q == LvlW'(Depth);
  assign empty = level_q == '0;
  // simultaneous push and pop is a tail-chain: the saved context is reused untouched
  assign do_push = push & ~pop & ~full;
  assign do_pop = pop & ~push & ~empty;
  assign push_err = push & ~pop & full;
  assign pop_err = pop & ~push & empty;
  assign top_idx = IdxW'(level_q - LvlW'(1));
  always_comb level_d = do_push ? level_q + LvlW'(1) : do_pop ? level_q - LvlW'(1) : level_q;
  always_ff @(posedge clk) begin
    if (reset) level_q <= '0;
    else level_q <= level_d;
  end
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[IdxW'(level_q)] <= push_addr;
      prio_q[IdxW'(level_q)] <= push_prio;
    end
  end
  assign ret_valid = ~empty;
  assign ret_addr = empty ? '0 : addr_q[top_idx];
  assign ret_prio = empty ? '0 : prio_q[top_idx];
  assign level = level_q;
`ifdef INTERRUPT_RETURN_STACK_ERR_EN
  logic overflow_q, underflow_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q <= push_err | (overflow_q & ~clear_err);
      underflow_q <= pop_err | (underflow_q & ~clear_err);
    end
  end
  assign overflow = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err;
  assign unused_err = clear_err ^ push_err ^ pop_err;
  assign overflow = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule
